// File: rtl/elevator_door_sequencer.sv
// elevator_door_sequencer
//   Door controller for the car. Latches hall/car calls as pending stops,
//   opens the door when the stopped car sits at a pending floor, and runs a
//   timed CLOSED -> OPENING -> OPEN -> CLOSING -> CLOSED cycle. door_busy
//   inhibits motion for the whole cycle; served pulses the retired floor.
//
//   Ports:
//     clk, reset          rising-edge clock, synchronous active-high reset
//     req_in [N]          button presses (any number of bits per cycle)
//     floor_at [N]        floor sensors, one-hot at a floor, zero between
//     car_moving          car in motion
//     obstruct            door-edge sensor (DOOR_REOPEN_EN builds only)
//     pending [N]         latched outstanding requests
//     door_open           door fully open
//     door_busy           motion inhibit, high in every state but CLOSED
//     served [N]          one-cycle pulse at OPEN entry, floor serviced
//     fault               sticky: car_moving seen while door_busy
//     state [2]           debug: 0 CLOSED, 1 OPENING, 2 OPEN, 3 CLOSING
//
//   Build option: define DOOR_REOPEN_EN to let obstruct reopen a closing
//   door and hold the dwell timer while open. Otherwise obstruct is ignored.
module elevator_door_sequencer #(
  parameter int N_FLOORS     = 5,
  parameter int OPEN_CYCLES  = 4,
  parameter int DWELL_CYCLES = 16,
  parameter int CLOSE_CYCLES = 4,
  parameter int CNT_W        = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_FLOORS-1:0] req_in,
  input  logic [N_FLOORS-1:0] floor_at,
  input  logic                car_moving,
  input  logic                obstruct,
  output logic [N_FLOORS-1:0] pending,
  output logic                door_open,
  output logic                door_busy,
  output logic [N_FLOORS-1:0] served,
  output logic                fault,
  output logic [1:0]          state
);

  typedef enum logic [1:0] {
    CLOSED  = 2'd0,
    OPENING = 2'd1,
    OPEN    = 2'd2,
    CLOSING = 2'd3
  } door_state_t;

  localparam logic [CNT_W-1:0] OPEN_LAST  = CNT_W'(OPEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLOSE_LAST = CNT_W'(CLOSE_CYCLES - 1);

  door_state_t         st;
  logic [CNT_W-1:0]    cnt;
  logic                reopen;   // current OPENING came from an obstruction
  logic                obs;
  logic                floor_valid;
  logic [N_FLOORS-1:0] pend_or_req;
  logic [N_FLOORS-1:0] hit;
  logic [N_FLOORS-1:0] here_req;

`ifdef DOOR_REOPEN_EN
  assign obs = obstruct;
`else
  logic unused_obstruct;
  assign unused_obstruct = obstruct;
  assign obs = 1'b0;
`endif

  always_comb begin
    floor_valid = (floor_at != '0) &&
                  ((floor_at & (floor_at - N_FLOORS'(1))) == '0);
    pend_or_req = pending | req_in;
    hit         = pend_or_req & floor_at;
    here_req    = req_in & floor_at;
  end

  assign state = st;

  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= CLOSED;
      cnt       <= '0;
      reopen    <= 1'b0;
      pending   <= '0;
      served    <= '0;
      door_open <= 1'b0;
      door_busy <= 1'b0;
      fault     <= 1'b0;
    end else begin
      served <= '0;
      if (car_moving && st != CLOSED) fault <= 1'b1;

      case (st)
        CLOSED: begin
          pending <= pend_or_req;
          if (!car_moving && floor_valid && (hit != '0)) begin
            st        <= OPENING;
            cnt       <= '0;
            reopen    <= 1'b0;
            door_busy <= 1'b1;
          end
        end

        OPENING: begin
          if (cnt == OPEN_LAST) begin
            st        <= OPEN;
            cnt       <= '0;
            door_open <= 1'b1;
            reopen    <= 1'b0;
            if (reopen) begin
              // A reopen is not a new service: keep the call latched.
              pending <= pend_or_req;
            end else begin
              served  <= hit;
              pending <= pend_or_req & ~floor_at;
            end
          end else begin
            cnt     <= cnt + CNT_W'(1);
            pending <= pend_or_req;
          end
        end

        OPEN: begin
          // Calls at the open floor extend the dwell instead of latching.
          pending <= pending | (req_in & ~floor_at);
          if ((here_req != '0) || obs) begin
            cnt <= '0;
          end else if (cnt == DWELL_LAST) begin
            st        <= CLOSING;
            cnt       <= '0;
            door_open <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        CLOSING: begin
          pending <= pend_or_req;
          if (obs) begin
            st     <= OPENING;
            cnt    <= '0;
            reopen <= 1'b1;
          end else if (cnt == CLOSE_LAST) begin
            st        <= CLOSED;
            cnt       <= '0;
            door_busy <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          st <= CLOSED;
        end
      endcase
    end
  end

endmodule

// File: doc/elevator_door_sequencer.md
Name: elevator_door_sequencer

Overview:
Sequential door controller for the 5-floor car. Latches hall/car call buttons as pending stops and detects arrival at a pending floor while the car is stopped. Runs a timed door cycle: CLOSED -> OPENING -> OPEN -> CLOSING -> CLOSED. Holds a motion-inhibit to the floor-state logic for the whole cycle and pulses a served flag so the serviced request is retired.

Parameters:
N_FLOORS, 5, number of floors; width of all one-hot floor buses
OPEN_CYCLES, 4, clock cycles spent in OPENING (min 1)
DWELL_CYCLES, 16, clock cycles spent in OPEN (min 1)
CLOSE_CYCLES, 4, clock cycles spent in CLOSING (min 1)
CNT_W, 8, phase counter width; must hold max(OPEN_CYCLES, DWELL_CYCLES, CLOSE_CYCLES)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
req_in  input  N_FLOORS  button presses, any number of bits per cycle
floor_at  input  N_FLOORS  floor sensors; one-hot at a floor, all-zero between floors
car_moving  input  1  car in motion
obstruct  input  1  door-edge sensor (used only with DOOR_REOPEN_EN)
pending  output  N_FLOORS  latched outstanding requests
door_open  output  1  door fully open
door_busy  output  1  motion inhibit; high in every state except CLOSED
served  output  N_FLOORS  one-cycle pulse, one-hot: floor just serviced
fault  output  1  sticky; car_moving seen while door_busy
state  output  2  debug: 0 CLOSED, 1 OPENING, 2 OPEN, 3 CLOSING

Behaviour:
- Reset: state CLOSED; pending, served, counter all 0; door_open, door_busy, fault 0. Reset mid-cycle abandons the door cycle and drops all pending requests.
- All outputs are registered.
- floor_valid = floor_at has exactly one bit set. Zero or multi-hot counts as invalid.
- hit = (pending | req_in) & floor_at.
- pending update, each edge: pending <= (pending | req_in) & ~clear.
  - clear = floor_at on the edge entering OPEN.
  - Exception: while in OPEN, req_in bits matching floor_at are not latched. Each such bit reloads the dwell counter to 0 (door stays open).
  - Set wins over clear for any other overlap.
- CLOSED -> OPENING when car_moving=0, floor_valid=1 and hit!=0. Latency is one edge from the request (or arrival) cycle. The counter is cleared on entry. door_busy=1 from the OPENING entry edge.
- Invalid floor_at or car_moving=1 in CLOSED: remain CLOSED and latch requests only.
- OPENING: counter increments each cycle. When counter=OPEN_CYCLES-1, go to OPEN and clear the counter. OPENING lasts exactly OPEN_CYCLES cycles.
- Edge entering OPEN: door_open<=1, served<=floor_at & (pending | req_in) for one cycle, and that pending bit is cleared.
- OPEN: counts DWELL_CYCLES, subject to reload, then goes to CLOSING. door_open<=0 on that edge.
- CLOSING: counts CLOSE_CYCLES, then goes to CLOSED. door_busy<=0 on that edge.
- Next door cycle: a new hit at the same floor while in CLOSING does not reopen the door. It is latched and triggers a fresh cycle once CLOSED.
- fault: set on any edge where car_moving=1 and state!=CLOSED. Cleared only by reset. The FSM continues normally.
- served is never asserted outside the OPEN-entry edge.

Optional Feature:
DOOR_REOPEN_EN defined:
- obstruct=1 during CLOSING moves the FSM to OPENING on the next edge, counter cleared. No served pulse on re-entering OPEN.
- obstruct=1 during OPEN holds the dwell counter at 0.
Undefined:
- obstruct is ignored, and the door cycle is purely timed.

Test Plan:
- Reset, then floor_at=00100, car_moving=0, req_in=00100 for 1 cycle at cycle 0 -> state OPENING after edge 1. OPEN after edge 5, with served=00100 for one cycle and pending=00000. door_open high for exactly 16 cycles. CLOSING after edge 21. CLOSED and door_busy=0 after edge 25.
- req_in=10010 while floor_at=00000 and car_moving=1 -> pending=10010, state stays CLOSED. Then floor_at=00010, car_moving=0 -> OPENING next edge, and pending=10000 after OPEN entry.
- Request at the current floor 8 cycles into OPEN -> dwell restarts, door_open lasts 8+16=24 cycles, pending bit never set.
- car_moving=1 during OPEN -> fault=1 sticky, FSM still completes. reset=1 during OPEN -> next edge all outputs 0, state CLOSED.
- DOOR_REOPEN_EN: obstruct=1 at CLOSING cycle 2 -> OPENING next edge, then OPEN again with no served pulse. Without the macro, the same stimulus gives CLOSED at the nominal time.
- floor_at=00110 (invalid) with pending=00100, car stopped -> remains CLOSED, door_busy=0.
